// File: rtl/membus_arbiter_if.sv
// membus_arbiter_if: native memory bus (valid/ready handshake, 32-bit address/data, byte strobes).
// The master modport is the requesting side; the slave modport is the responding side.
interface membus_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (
    output valid,
    output addr,
    output wdata,
    output wstrb,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  addr,
    input  wdata,
    input  wstrb,
    output ready,
    output rdata
  );
endinterface

// File: rtl/membus_arbiter.sv
// membus_arbiter: shares one slave-side memory bus between two masters. The grant is held for a
// whole transfer, and a watchdog completes transfers that no slave acknowledges.
module membus_arbiter #(
  parameter int unsigned ARB_MODE       = 0,      // 0 = round-robin, 1 = fixed priority (m0)
  parameter int unsigned TIMEOUT_CYCLES = 255,    // 0 disables the watchdog
  parameter logic [31:0] ERR_RDATA      = 32'h0
) (
  input  logic             clk,
  input  logic             resetn,
  membus_arbiter_if.slave  m0,
  membus_arbiter_if.slave  m1,
  membus_arbiter_if.master s,
  output logic             bus_err,
  output logic [31:0]      err_addr
);

  localparam int unsigned     CntW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StGnt0 = 2'd1;
  localparam logic [1:0] StGnt1 = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic        gnt0, gnt1;
  logic        sel_valid;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        timeout, done, pick;

  // Select the granted master's request; everything reads as zero while idle.
  always_comb begin
    gnt0      = (state_q == StGnt0);
    gnt1      = (state_q == StGnt1);
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    if (gnt0) begin
      sel_valid = m0.valid;
      sel_addr  = m0.addr;
      sel_wdata = m0.wdata;
      sel_wstrb = m0.wstrb;
    end else if (gnt1) begin
      sel_valid = m1.valid;
      sel_addr  = m1.addr;
      sel_wdata = m1.wdata;
      sel_wstrb = m1.wstrb;
    end
  end

  // Bus outputs; a slave acknowledge in the expiry cycle beats the watchdog.
  always_comb begin
    timeout  = (TIMEOUT_CYCLES != 0) && sel_valid && (cnt_q == CntMax) && !s.ready;
    s.valid  = sel_valid & ~timeout;
    s.addr   = sel_addr;
    s.wdata  = sel_wdata;
    s.wstrb  = sel_wstrb;
    done     = s.valid & s.ready;
    m0.ready = gnt0 & (done | timeout);
    m1.ready = gnt1 & (done | timeout);
    m0.rdata = m0.ready ? (timeout ? ERR_RDATA : s.rdata) : '0;
    m1.rdata = m1.ready ? (timeout ? ERR_RDATA : s.rdata) : '0;
    bus_err  = timeout;
  end

  // Arbitration, transfer completion and watchdog counting.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_addr_d = err_addr_q;
    pick       = 1'b0;
    if (state_q == StIdle) begin
      if (m0.valid || m1.valid) begin
        if (m0.valid && m1.valid) begin
          pick = (ARB_MODE != 0) ? 1'b0 : ~last_q;
        end else begin
          pick = m1.valid;
        end
        state_d = pick ? StGnt1 : StGnt0;
        last_d  = pick;
        cnt_d   = '0;
      end
    end else if (done || timeout || !sel_valid) begin
      // Also covers a master withdrawing its request and any unused encoding.
      state_d = StIdle;
      if (timeout) begin
        err_addr_d = sel_addr;
      end
    end else if (!s.ready && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_addr = err_addr_q;

endmodule
